// File: rtl/serdiv_issue_unit.sv
// Issue unit for the serial divider: queues client divide requests, issues them one at a time
// with incrementing trans IDs, and returns each result. Optional perf counters: SERDIV_ISSUE_PERF_EN.
module serdiv_issue_unit #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned DEPTH   = 4,
  // Matches ariane_pkg::TRANS_ID_BITS in the default CVA6 configuration.
  parameter int unsigned ID_BITS = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               req_vld_i,
  output logic               req_rdy_o,
  input  logic [1:0]         req_opcode_i,
  input  logic [WIDTH-1:0]   req_a_i,
  input  logic [WIDTH-1:0]   req_b_i,
  input  logic               req_a_label_i,
  input  logic               req_b_label_i,
  output logic               div_vld_o,
  input  logic               div_rdy_i,
  output logic [ID_BITS-1:0] div_id_o,
  output logic [1:0]         div_opcode_o,
  output logic [WIDTH-1:0]   div_a_o,
  output logic [WIDTH-1:0]   div_b_o,
  output logic               div_a_label_o,
  output logic               div_b_label_o,
  output logic               div_flush_o,
  input  logic               div_res_vld_i,
  output logic               div_res_rdy_o,
  input  logic [ID_BITS-1:0] div_res_id_i,
  input  logic [WIDTH-1:0]   div_res_i,
  input  logic               div_res_label_i,
  output logic               rsp_vld_o,
  input  logic               rsp_rdy_i,
  output logic [ID_BITS-1:0] rsp_id_o,
  output logic [WIDTH-1:0]   rsp_res_o,
  output logic               rsp_label_o,
  output logic               rsp_err_o
`ifdef SERDIV_ISSUE_PERF_EN
  ,
  output logic [31:0]        perf_lat_o,
  output logic [31:0]        perf_ops_o
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 2 + 2 * WIDTH + 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Handshakes: a transfer happens on the cycle where valid and ready are both high at the
  // rising edge; the sender holds valid and payload stable until then.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e state_q, state_d;

  logic [EW-1:0]      mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [ID_BITS-1:0] id_cnt_q, id_cnt_d;
  logic [ID_BITS-1:0] issued_id_q, issued_id_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               res_label_q, res_label_d;
  logic [ID_BITS-1:0] res_id_q, res_id_d;
  logic               res_err_q, res_err_d;

  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          res_cap;
  logic [EW-1:0] entry_in;
  logic [EW-1:0] head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign req_rdy_o  = rst_ni && !fifo_full;
  assign push       = req_vld_i && req_rdy_o && !flush_i;
  assign pop        = (state_q == S_ISSUE) && div_rdy_i && !flush_i;
  assign res_cap    = (state_q == S_WAIT) && div_res_vld_i && !flush_i;
  assign entry_in   = {req_opcode_i, req_a_i, req_b_i, req_a_label_i, req_b_label_i};
  assign head       = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= entry_in;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Next-state logic; a push landing in the same cycle as the response handshake counts as work.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_ISSUE;
      S_ISSUE: if (div_rdy_i) state_d = S_WAIT;
      S_WAIT:  if (div_res_vld_i) state_d = S_RESP;
      S_RESP:  if (rsp_rdy_i) state_d = (!fifo_empty || push) ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_comb begin
    id_cnt_d    = id_cnt_q;
    issued_id_d = issued_id_q;
    res_d       = res_q;
    res_label_d = res_label_q;
    res_id_d    = res_id_q;
    res_err_d   = res_err_q;
    if (pop) begin
      issued_id_d = id_cnt_q;
      id_cnt_d    = id_cnt_q + ID_BITS'(1);
    end
    if (res_cap) begin
      res_d       = div_res_i;
      res_label_d = div_res_label_i;
      res_id_d    = div_res_id_i;
      res_err_d   = (div_res_id_i != issued_id_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      id_cnt_q    <= '0;
      issued_id_q <= '0;
      res_q       <= '0;
      res_label_q <= 1'b0;
      res_id_q    <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      id_cnt_q    <= id_cnt_d;
      issued_id_q <= issued_id_d;
      res_q       <= res_d;
      res_label_q <= res_label_d;
      res_id_q    <= res_id_d;
      res_err_q   <= res_err_d;
    end
  end

  // Payload outputs are zero outside the state that validates them.
  always_comb begin
    div_flush_o   = flush_i;
    div_vld_o     = (state_q == S_ISSUE);
    div_res_rdy_o = (state_q == S_WAIT);
    rsp_vld_o     = (state_q == S_RESP);
    div_id_o      = '0;
    {div_opcode_o, div_a_o, div_b_o, div_a_label_o, div_b_label_o} = '0;
    rsp_id_o      = '0;
    rsp_res_o     = '0;
    rsp_label_o   = 1'b0;
    rsp_err_o     = 1'b0;
    if (state_q == S_ISSUE) begin
      div_id_o = id_cnt_q;
      {div_opcode_o, div_a_o, div_b_o, div_a_label_o, div_b_label_o} = head;
    end
    if (state_q == S_RESP) begin
      rsp_id_o    = res_id_q;
      rsp_res_o   = res_q;
      rsp_label_o = res_label_q;
      rsp_err_o   = res_err_q;
    end
  end

`ifdef SERDIV_ISSUE_PERF_EN
  logic [31:0] lat_run_q, lat_run_d;
  logic [31:0] perf_lat_q, perf_lat_d;
  logic [31:0] perf_ops_q, perf_ops_d;
  logic        rsp_hs;

  assign rsp_hs = (state_q == S_RESP) && rsp_rdy_i && !flush_i;

  // lat_run counts WAIT cycles; the capture cycle itself is included in the reported value.
  always_comb begin
    lat_run_d  = lat_run_q;
    perf_lat_d = perf_lat_q;
    perf_ops_d = perf_ops_q;
    if (pop) begin
      lat_run_d = '0;
    end else if (state_q == S_WAIT) begin
      lat_run_d = lat_run_q + 32'd1;
    end
    if (res_cap) perf_lat_d = lat_run_q + 32'd1;
    if (rsp_hs && (perf_ops_q != 32'hFFFF_FFFF)) perf_ops_d = perf_ops_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lat_run_q  <= '0;
      perf_lat_q <= '0;
      perf_ops_q <= '0;
    end else begin
      lat_run_q  <= lat_run_d;
      perf_lat_q <= perf_lat_d;
      perf_ops_q <= perf_ops_d;
    end
  end

  assign perf_lat_o = perf_lat_q;
  assign perf_ops_o = perf_ops_q;
`endif

endmodule

// File: tb/tb_serdiv_issue_unit.sv
// Directed bench for serdiv_issue_unit; the bench itself plays the client and the divider.
module tb_serdiv_issue_unit;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        req_vld_i;
  logic        req_rdy_o;
  logic [1:0]  req_opcode_i;
  logic [63:0] req_a_i, req_b_i;
  logic        req_a_label_i, req_b_label_i;
  logic        div_vld_o, div_rdy_i;
  logic [2:0]  div_id_o;
  logic [1:0]  div_opcode_o;
  logic [63:0] div_a_o, div_b_o;
  logic        div_a_label_o, div_b_label_o, div_flush_o;
  logic        div_res_vld_i, div_res_rdy_o;
  logic [2:0]  div_res_id_i;
  logic [63:0] div_res_i;
  logic        div_res_label_i;
  logic        rsp_vld_o, rsp_rdy_i;
  logic [2:0]  rsp_id_o;
  logic [63:0] rsp_res_o;
  logic        rsp_label_o, rsp_err_o;
`ifdef SERDIV_ISSUE_PERF_EN
  logic [31:0] perf_lat_o, perf_ops_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int ops_done = 0;

  // Directed vectors: opcode, a, b, labels, model result and model result label.
  logic [1:0]  v_op [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
  logic [63:0] v_a  [7] = '{64'd2, 64'd50, 64'd17, 64'hFFFF_FFFF_FFFF_FFEF, 64'd1000,
                            64'hFFFF_FFFF_FFFF_FF9C, 64'd9};
  logic [63:0] v_b  [7] = '{64'd10, 64'd7, 64'd5, 64'd5, 64'd8, 64'd4, 64'd9};
  logic        v_la [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        v_lb [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [63:0] v_res[7] = '{64'd0, 64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd125,
                            64'hFFFF_FFFF_FFFF_FFE7, 64'd0};
  logic        v_rl [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  serdiv_issue_unit #(.WIDTH(64), .DEPTH(4), .ID_BITS(3)) dut (
`ifdef SERDIV_ISSUE_PERF_EN
    .perf_lat_o(perf_lat_o),
    .perf_ops_o(perf_ops_o),
`endif
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_opcode_i(req_opcode_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .req_a_label_i(req_a_label_i), .req_b_label_i(req_b_label_i),
    .div_vld_o(div_vld_o), .div_rdy_i(div_rdy_i), .div_id_o(div_id_o),
    .div_opcode_o(div_opcode_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
    .div_a_label_o(div_a_label_o), .div_b_label_o(div_b_label_o), .div_flush_o(div_flush_o),
    .div_res_vld_i(div_res_vld_i), .div_res_rdy_o(div_res_rdy_o), .div_res_id_i(div_res_id_i),
    .div_res_i(div_res_i), .div_res_label_i(div_res_label_i),
    .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i), .rsp_id_o(rsp_id_o),
    .rsp_res_o(rsp_res_o), .rsp_label_o(rsp_label_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; flush_i = 1'b0; req_vld_i = 1'b0; div_rdy_i = 1'b0;
    div_res_vld_i = 1'b0; rsp_rdy_i = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_rdy", req_rdy_o, 1'b0);
    check_eq("rst_div_vld", div_vld_o, 1'b0);
    check_eq("rst_rsp_vld", rsp_vld_o, 1'b0);
    rst_ni = 1'b1;
    ops_done = 0;
    @(negedge clk);
    check_eq("post_rst_req_rdy", req_rdy_o, 1'b1);
    check_eq("post_rst_res_rdy", div_res_rdy_o, 1'b0);
    check_eq("post_rst_flush", div_flush_o, 1'b0);
    check_eq("post_rst_rsp_res", rsp_res_o, 64'd0);
    @(negedge clk);
    check_eq("post_rst_div_vld", div_vld_o, 1'b0);
    check_eq("post_rst_rsp_vld", rsp_vld_o, 1'b0);
  endtask

  task automatic push_req(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic la, input logic lb);
    int n;
    req_opcode_i = op; req_a_i = a; req_b_i = b; req_a_label_i = la; req_b_label_i = lb;
    req_vld_i = 1'b1;
    n = 0;
    while (!req_rdy_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check_eq("push_timeout", 1'b0, 1'b1);
    @(negedge clk);
    req_vld_i = 1'b0;
  endtask

  // Divider model plus client response side for one operation.
  task automatic serve(input logic [1:0] e_op, input logic [63:0] e_a, input logic [63:0] e_b,
                       input logic e_la, input logic e_lb, input logic [2:0] e_id,
                       input logic [63:0] res, input logic rl, input logic [2:0] ret_id,
                       input int rdy_wait, input int lat, input int rsp_wait);
    int n;
    n = 0;
    while (!div_vld_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("issue_vld", div_vld_o, 1'b1);
    for (int k = 0; k <= rdy_wait; k++) begin
      if (k > 0) @(negedge clk);
      check_eq("issue_hold_vld", div_vld_o, 1'b1);
      check_eq("issue_id", div_id_o, e_id);
      check_eq("issue_op", div_opcode_o, e_op);
      check_eq("issue_a", div_a_o, e_a);
      check_eq("issue_b", div_b_o, e_b);
      check_eq("issue_labels", {div_a_label_o, div_b_label_o}, {e_la, e_lb});
    end
    div_rdy_i = 1'b1;
    @(negedge clk);
    div_rdy_i = 1'b0;
    check_eq("wait_div_vld", div_vld_o, 1'b0);
    check_eq("wait_res_rdy", div_res_rdy_o, 1'b1);
    repeat (lat - 1) @(negedge clk);
    check_eq("wait_res_rdy_late", div_res_rdy_o, 1'b1);
    div_res_vld_i = 1'b1; div_res_id_i = ret_id; div_res_i = res; div_res_label_i = rl;
    @(negedge clk);
    div_res_vld_i = 1'b0; div_res_id_i = ~ret_id; div_res_i = ~res; div_res_label_i = ~rl;
    for (int k = 0; k <= rsp_wait; k++) begin
      if (k > 0) @(negedge clk);
      check_eq("rsp_vld", rsp_vld_o, 1'b1);
      check_eq("rsp_id", rsp_id_o, ret_id);
      check_eq("rsp_res", rsp_res_o, res);
      check_eq("rsp_label", rsp_label_o, rl);
      check_eq("rsp_err", rsp_err_o, (ret_id != e_id));
      check_eq("rsp_res_rdy_low", div_res_rdy_o, 1'b0);
    end
    rsp_rdy_i = 1'b1;
    @(negedge clk);
    rsp_rdy_i = 1'b0;
    ops_done++;
    check_eq("rsp_vld_drop", rsp_vld_o, 1'b0);
`ifdef SERDIV_ISSUE_PERF_EN
    check_eq("perf_ops", perf_ops_o, ops_done);
    check_eq("perf_lat", perf_lat_o, lat);
`endif
  endtask

  initial begin
    req_opcode_i = '0; req_a_i = '0; req_b_i = '0; req_a_label_i = 1'b0; req_b_label_i = 1'b0;
    div_res_id_i = '0; div_res_i = '0; div_res_label_i = 1'b0;

    // Single udiv after reset.
    do_reset();
    push_req(2'd0, 64'd100, 64'd5, 1'b1, 1'b1);
    serve(2'd0, 64'd100, 64'd5, 1'b1, 1'b1, 3'd0, 64'd20, 1'b1, 3'd0, 0, 4, 0);

    // Back-to-back: seven requests, FIFO fills while the first issue is stalled.
    do_reset();
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          push_req(v_op[i], v_a[i], v_b[i], v_la[i], v_lb[i]);
          if (i == 3) check_eq("fifo_full_rdy", req_rdy_o, 1'b0);
        end
      end
      begin
        for (int i = 0; i < 7; i++)
          serve(v_op[i], v_a[i], v_b[i], v_la[i], v_lb[i], 3'(i), v_res[i], v_rl[i], 3'(i),
                (i == 0) ? 10 : 0, 2, 0);
      end
    join

    // Reset in the middle of an issue aborts it.
    push_req(2'd0, 64'd8, 64'd2, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("pre_abort_vld", div_vld_o, 1'b1);
    do_reset();

    // ID mismatch on the third op.
    push_req(2'd0, 64'd6, 64'd3, 1'b0, 1'b0);
    serve(2'd0, 64'd6, 64'd3, 1'b0, 1'b0, 3'd0, 64'd2, 1'b0, 3'd0, 0, 1, 0);
    push_req(2'd2, 64'd7, 64'd4, 1'b1, 1'b0);
    serve(2'd2, 64'd7, 64'd4, 1'b1, 1'b0, 3'd1, 64'd3, 1'b1, 3'd1, 0, 1, 0);
    push_req(2'd0, 64'd30, 64'd6, 1'b0, 1'b1);
    serve(2'd0, 64'd30, 64'd6, 1'b0, 1'b1, 3'd2, 64'd5, 1'b1, 3'd5, 0, 2, 0);

    // Flush while waiting with two requests queued and a same-cycle push.
    push_req(2'd0, 64'd40, 64'd4, 1'b0, 1'b0);
    begin
      int n = 0;
      while (!div_vld_o && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("flush_issue_id", div_id_o, 3'd3);
    div_rdy_i = 1'b1;
    @(negedge clk);
    div_rdy_i = 1'b0;
    push_req(2'd0, 64'd11, 64'd1, 1'b0, 1'b0);
    push_req(2'd0, 64'd12, 64'd1, 1'b0, 1'b0);
    check_eq("flush_in_wait", div_res_rdy_o, 1'b1);
    flush_i = 1'b1;
    req_vld_i = 1'b1; req_a_i = 64'd13;
    check_eq("div_flush_hi", div_flush_o, 1'b1);
    @(negedge clk);
    flush_i = 1'b0;
    req_vld_i = 1'b0;
    check_eq("div_flush_lo", div_flush_o, 1'b0);
    for (int k = 0; k < 6; k++) begin
      check_eq("flush_no_rsp", rsp_vld_o, 1'b0);
      check_eq("flush_no_issue", div_vld_o, 1'b0);
      @(negedge clk);
    end
    check_eq("flush_req_rdy", req_rdy_o, 1'b1);
    push_req(2'd0, 64'd1000, 64'd20, 1'b0, 1'b0);
    serve(2'd0, 64'd1000, 64'd20, 1'b0, 1'b0, 3'd4, 64'd50, 1'b0, 3'd4, 0, 1, 0);

    // Backpressure on both handshakes.
    push_req(2'd0, 64'd81, 64'd9, 1'b1, 1'b0);
    serve(2'd0, 64'd81, 64'd9, 1'b1, 1'b0, 3'd5, 64'd9, 1'b1, 3'd5, 5, 3, 3);

    // Long divider latency.
    push_req(2'd0, 64'd7, 64'd2, 1'b0, 1'b1);
    serve(2'd0, 64'd7, 64'd2, 1'b0, 1'b1, 3'd6, 64'd3, 1'b1, 3'd6, 0, 66, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
